// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between two write-back requesters.
// Each requester feeds an in-order FIFO; a round-robin picker drains one head per cycle.

module regfile_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [4:0]    push_rd,
  input  logic [DW-1:0] push_wd,
  output logic          ready,
  output logic          not_empty,
  output logic [4:0]    head_rd,
  output logic [DW-1:0] head_wd,
  output logic [31:0]   pending
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] wd;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign ready     = (count < CW'(DEPTH));
  assign not_empty = (count != '0);
  assign head_rd   = mem[rd_ptr].rd;
  assign head_wd   = mem[rd_ptr].wd;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].rd <= push_rd;
      mem[wr_ptr].wd <= push_wd;
    end
  end

  // Slot i is live when its distance from the read pointer is below count
  always_comb begin
    logic [AW-1:0] off;
    pending = '0;
    off     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count) pending[mem[i].rd] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule

module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [4:0]    req0_rd,
  input  logic [DW-1:0] req0_wd,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [4:0]    req1_rd,
  input  logic [DW-1:0] req1_wd,
  output logic          wb_we,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_wd,
  output logic          wb_src,
  output logic [31:0]   pending
);
  logic          push0;
  logic          push1;
  logic          pop0;
  logic          pop1;
  logic          ne0;
  logic          ne1;
  logic          last_grant;
  logic [4:0]    head0_rd;
  logic [4:0]    head1_rd;
  logic [DW-1:0] head0_wd;
  logic [DW-1:0] head1_wd;
  logic [31:0]   pend0;
  logic [31:0]   pend1;

  // Writes to x0 complete the handshake but are dropped before queueing
  assign push0 = req0_valid && req0_ready && (req0_rd != 5'd0);
  assign push1 = req1_valid && req1_ready && (req1_rd != 5'd0);

  regfile_wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .pop       (pop0),
    .push_rd   (req0_rd),
    .push_wd   (req0_wd),
    .ready     (req0_ready),
    .not_empty (ne0),
    .head_rd   (head0_rd),
    .head_wd   (head0_wd),
    .pending   (pend0)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .pop       (pop1),
    .push_rd   (req1_rd),
    .push_wd   (req1_wd),
    .ready     (req1_ready),
    .not_empty (ne1),
    .head_rd   (head1_rd),
    .head_wd   (head1_wd),
    .pending   (pend1)
  );

  // last_grant = 1 means req1 won last, so req0 takes the next tie
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (ne0 && ne1) begin
      pop0 = last_grant;
      pop1 = !last_grant;
    end else begin
      pop0 = ne0;
      pop1 = ne1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (pop0) begin
      last_grant <= 1'b0;
    end else if (pop1) begin
      last_grant <= 1'b1;
    end
  end

  always_comb begin
    wb_we  = 1'b0;
    wb_rd  = '0;
    wb_wd  = '0;
    wb_src = 1'b0;
    if (pop0) begin
      wb_we = 1'b1;
      wb_rd = head0_rd;
      wb_wd = head0_wd;
    end else if (pop1) begin
      wb_we  = 1'b1;
      wb_rd  = head1_rd;
      wb_wd  = head1_wd;
      wb_src = 1'b1;
    end
  end

  assign pending = pend0 | pend1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: hand-derived vector table, async-reset sequence,
// and randomized traffic checked against a queue-based reference model.

module tb_regfile_wb_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned DW    = 64;
  localparam int          NV    = 17;

  logic          clk;
  logic          reset;
  logic          req0_valid;
  logic          req0_ready;
  logic [4:0]    req0_rd;
  logic [DW-1:0] req0_wd;
  logic          req1_valid;
  logic          req1_ready;
  logic [4:0]    req1_rd;
  logic [DW-1:0] req1_wd;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_wd;
  logic          wb_src;
  logic [31:0]   pending;

  int n_vec;
  int n_err;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] wd;
  } entry_t;

  entry_t q0[$];
  entry_t q1[$];
  bit     lg;

  typedef struct {
    bit            rst;
    bit            v0;
    logic [4:0]    rd0;
    logic [DW-1:0] wd0;
    bit            v1;
    logic [4:0]    rd1;
    logic [DW-1:0] wd1;
    bit            we;
    logic [4:0]    rd;
    logic [DW-1:0] wd;
    bit            src;
    logic [31:0]   pend;
    bit            r0;
    bit            r1;
  } vec_t;

  vec_t tbl[NV];

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rd    (req0_rd),
    .req0_wd    (req0_wd),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rd    (req1_rd),
    .req1_wd    (req1_wd),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_wd      (wb_wd),
    .wb_src     (wb_src),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, bit v0, logic [4:0] rd0, logic [DW-1:0] wd0,
                              bit v1, logic [4:0] rd1, logic [DW-1:0] wd1,
                              bit we, logic [4:0] rd, logic [DW-1:0] wd, bit src,
                              logic [31:0] pend, bit r0, bit r1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.rd0 = rd0; v.wd0 = wd0;
    v.v1 = v1; v.rd1 = rd1; v.wd1 = wd1;
    v.we = we; v.rd = rd; v.wd = wd; v.src = src;
    v.pend = pend; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic check(string name, bit e_we, logic [4:0] e_rd, logic [DW-1:0] e_wd,
                       bit e_src, logic [31:0] e_pend, bit e_r0, bit e_r1);
    n_vec++;
    if (wb_we !== e_we || wb_rd !== e_rd || wb_wd !== e_wd || wb_src !== e_src ||
        pending !== e_pend || req0_ready !== e_r0 || req1_ready !== e_r1) begin
      n_err++;
      $display("FAIL %s @%0t: got we=%0b rd=%0d wd=%h src=%0b pend=%h rdy=%0b%0b; want we=%0b rd=%0d wd=%h src=%0b pend=%h rdy=%0b%0b",
               name, $time, wb_we, wb_rd, wb_wd, wb_src, pending, req0_ready, req1_ready,
               e_we, e_rd, e_wd, e_src, e_pend, e_r0, e_r1);
    end
  endtask

  task automatic drive(bit v0, logic [4:0] rd0, logic [DW-1:0] wd0,
                       bit v1, logic [4:0] rd1, logic [DW-1:0] wd1);
    req0_valid = v0; req0_rd = rd0; req0_wd = wd0;
    req1_valid = v1; req1_rd = rd1; req1_wd = wd1;
  endtask

  // Called at a negedge; reset must clear outputs without waiting for a clock edge
  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    lg = 1'b1;
    #1;
    check("reset_async", 1'b0, 5'd0, '0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: per-port queues, alternate when both hold entries
  task automatic model_out(output bit we, output logic [4:0] rd, output logic [DW-1:0] wd,
                           output bit src, output logic [31:0] pend,
                           output bit r0, output bit r1, output bit g0, output bit g1);
    g0 = (q0.size() != 0) && ((q1.size() == 0) || lg);
    g1 = (q1.size() != 0) && ((q0.size() == 0) || !lg);
    we = g0 || g1;
    rd = '0; wd = '0; src = 1'b0;
    if (g0) begin
      rd = q0[0].rd; wd = q0[0].wd;
    end else if (g1) begin
      rd = q1[0].rd; wd = q1[0].wd; src = 1'b1;
    end
    pend = '0;
    foreach (q0[i]) pend[q0[i].rd] = 1'b1;
    foreach (q1[i]) pend[q1[i].rd] = 1'b1;
    r0 = (q0.size() < int'(DEPTH));
    r1 = (q1.size() < int'(DEPTH));
  endtask

  task automatic cycle(bit v0, logic [4:0] rd0, logic [DW-1:0] wd0,
                       bit v1, logic [4:0] rd1, logic [DW-1:0] wd1,
                       output bit acc0, output bit acc1);
    bit            e_we, e_src, e_r0, e_r1, g0, g1;
    logic [4:0]    e_rd;
    logic [DW-1:0] e_wd;
    logic [31:0]   e_pend;
    entry_t        e;
    model_out(e_we, e_rd, e_wd, e_src, e_pend, e_r0, e_r1, g0, g1);
    check("model", e_we, e_rd, e_wd, e_src, e_pend, e_r0, e_r1);
    drive(v0, rd0, wd0, v1, rd1, wd1);
    acc0 = v0 && e_r0;
    acc1 = v1 && e_r1;
    if (g0) begin e = q0.pop_front(); lg = 1'b0; end
    if (g1) begin e = q1.pop_front(); lg = 1'b1; end
    if (acc0 && rd0 != 5'd0) begin e.rd = rd0; e.wd = wd0; q0.push_back(e); end
    if (acc1 && rd1 != 5'd0) begin e.rd = rd1; e.wd = wd1; q1.push_back(e); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit            v0, v1, acc0, acc1;
    logic [4:0]    rd0, rd1;
    logic [DW-1:0] wd0, wd1;

    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b1;
    lg    = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Expected outputs are those seen in the cycle after the row's edge
    tbl[0]  = mk(1, 1, 5'd5,  64'h1234, 0, 5'd0,  64'h0,    1, 5'd5,  64'h1234, 0, 32'h0000_0020, 1, 1);
    tbl[1]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 32'h0000_0000, 1, 1);
    tbl[2]  = mk(1, 1, 5'd3,  64'hA,    1, 5'd4,  64'hB,    1, 5'd3,  64'hA,    0, 32'h0000_0018, 1, 1);
    tbl[3]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 5'd4,  64'hB,    1, 32'h0000_0010, 1, 1);
    tbl[4]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 32'h0000_0000, 1, 1);
    tbl[5]  = mk(0, 0, 5'd0,  64'h0,    1, 5'd0,  64'hFFFF, 0, 5'd0,  64'h0,    0, 32'h0000_0000, 1, 1);
    tbl[6]  = mk(0, 1, 5'd7,  64'h1,    0, 5'd0,  64'h0,    1, 5'd7,  64'h1,    0, 32'h0000_0080, 1, 1);
    tbl[7]  = mk(0, 1, 5'd7,  64'h2,    0, 5'd0,  64'h0,    1, 5'd7,  64'h2,    0, 32'h0000_0080, 1, 1);
    tbl[8]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 32'h0000_0000, 1, 1);
    tbl[9]  = mk(1, 1, 5'd1,  64'h10,   1, 5'd2,  64'h20,   1, 5'd1,  64'h10,   0, 32'h0000_0006, 1, 1);
    tbl[10] = mk(0, 1, 5'd3,  64'h11,   1, 5'd6,  64'h21,   1, 5'd2,  64'h20,   1, 32'h0000_004C, 1, 0);
    tbl[11] = mk(0, 1, 5'd8,  64'h12,   1, 5'd9,  64'h22,   1, 5'd3,  64'h11,   0, 32'h0000_0148, 0, 1);
    tbl[12] = mk(0, 1, 5'd10, 64'h13,   1, 5'd9,  64'h22,   1, 5'd6,  64'h21,   1, 32'h0000_0340, 1, 0);
    tbl[13] = mk(0, 1, 5'd10, 64'h13,   1, 5'd11, 64'h23,   1, 5'd8,  64'h12,   0, 32'h0000_0700, 0, 1);
    tbl[14] = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 5'd9,  64'h22,   1, 32'h0000_0600, 1, 1);
    tbl[15] = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 5'd10, 64'h13,   0, 32'h0000_0400, 1, 1);
    tbl[16] = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 32'h0000_0000, 1, 1);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].v0, tbl[i].rd0, tbl[i].wd0, tbl[i].v1, tbl[i].rd1, tbl[i].wd1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].src,
            tbl[i].pend, tbl[i].r0, tbl[i].r1);
    end

    // Queue up writes on both ports, then reset mid-cycle and confirm they never emerge
    do_reset();
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 5'(11 + k), DW'(64'h100 + k), 1'b1, 5'(20 + k), DW'(64'h200 + k), acc0, acc1);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    lg = 1'b1;
    #1;
    check("mid_reset", 1'b0, 5'd0, '0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++)
      cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc0, acc1);

    // Randomized traffic; an unaccepted offer is either held unchanged or withdrawn
    do_reset();
    v0 = 1'b0; rd0 = '0; wd0 = '0; acc0 = 1'b0;
    v1 = 1'b0; rd1 = '0; wd1 = '0; acc1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        v0 = 1'b0; acc0 = 1'b0;
        v1 = 1'b0; acc1 = 1'b0;
      end
      if (v0 && !acc0) begin
        if ($urandom_range(0, 3) == 0) v0 = 1'b0;
      end else begin
        v0  = ($urandom_range(0, 3) != 0);
        rd0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wd0 = DW'({$urandom(), $urandom()});
      end
      if (v1 && !acc1) begin
        if ($urandom_range(0, 3) == 0) v1 = 1'b0;
      end else begin
        v1  = ($urandom_range(0, 3) != 0);
        rd1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wd1 = DW'({$urandom(), $urandom()});
      end
      cycle(v0, rd0, wd0, v1, rd1, wd1, acc0, acc1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
